// File: rtl/param_memory_if.sv
// rtl/param_memory_if.sv - request/response bundle for param_memory
//
// Purpose: groups the read/write/clear request signals and the registered
// read response of param_memory.
// Ports (signals):
//   ReadEnable, WriteEnable, ClearEnable  request strobes (master -> slave)
//   Address [ADDR_WIDTH]                  word address   (master -> slave)
//   DataIn  [DATA_WIDTH]                  write data     (master -> slave)
//   DataOut [DATA_WIDTH]                  read data      (slave -> master)
//   DataValid                             read data fresh this cycle
//   Ready                                 requests accepted this cycle
interface param_memory_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  logic                  ReadEnable;
  logic                  WriteEnable;
  logic                  ClearEnable;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] DataIn;
  logic [DATA_WIDTH-1:0] DataOut;
  logic                  DataValid;
  logic                  Ready;

  modport master (
    output ReadEnable, WriteEnable, ClearEnable, Address, DataIn,
    input  DataOut, DataValid, Ready
  );

  modport slave (
    input  ReadEnable, WriteEnable, ClearEnable, Address, DataIn,
    output DataOut, DataValid, Ready
  );
endinterface

// File: rtl/param_memory.sv
// rtl/param_memory.sv - single-port word memory with registered read and bulk clear
//
// Purpose: DEPTH = 2**ADDR_WIDTH words of DATA_WIDTH bits. One request per
// cycle (priority clear > read > write); a clear walks every address writing
// zero, one word per cycle, and blocks new requests while it runs.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (memory contents are not reset)
//   bus    param_memory_if slave modport (requests in, read response out)
module param_memory #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  param_memory_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    CLEAR = 2'd3
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  rd_fire;

  // Ready depends only on the state register, so there is no path from the
  // request inputs to Ready.
  assign bus.Ready = (state_q != CLEAR);

  always_comb begin
    state_d   = IDLE;
    mem_we    = 1'b0;
    mem_waddr = bus.Address;
    mem_wdata = bus.DataIn;
    rd_fire   = 1'b0;
    if (state_q == CLEAR) begin
      // Incoming requests are dropped here, not queued.
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
      state_d   = (&clr_cnt_q) ? IDLE : CLEAR;
    end else if (bus.ClearEnable) begin
      state_d = CLEAR;
    end else if (bus.ReadEnable) begin
      state_d = READ;
      rd_fire = 1'b1;
    end else if (bus.WriteEnable) begin
      state_d = WRITE;
      mem_we  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      clr_cnt_q     <= '0;
      bus.DataOut   <= '0;
      bus.DataValid <= 1'b0;
    end else begin
      state_q       <= state_d;
      bus.DataValid <= rd_fire;
      // Counter wraps to 0 on the last clear write, ready for the next clear.
      if (state_q == CLEAR) begin
        clr_cnt_q <= clr_cnt_q + 1'b1;
      end
      if (rd_fire) begin
        bus.DataOut <= mem[bus.Address];
      end
    end
  end

  // Storage has no reset; a read in the cycle after a write sees the new word.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end
endmodule

// File: tb/tb_param_memory.sv
// tb/tb_param_memory.sv - scoreboard bench for param_memory (16x16 and 64x32 instances)
module tb_param_memory;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  param_memory_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) a_if ();
  param_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) b_if ();

  param_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if.slave)
  );

  param_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if.slave)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] model_a [16];
  logic [31:0] model_b [64];
  logic [31:0] exp_a [$];
  logic [31:0] exp_b [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response side of the scoreboard: every DataValid pulse consumes one expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_if.DataValid === 1'b1) begin
        if (exp_a.size() == 0) check("a_spurious_valid", 1, 0);
        else check("a_rd_data", {16'h0, a_if.DataOut}, exp_a.pop_front());
      end else if (a_if.DataValid !== 1'b0) begin
        check("a_valid_x", a_if.DataValid, 0);
      end
      if (b_if.DataValid === 1'b1) begin
        if (exp_b.size() == 0) check("b_spurious_valid", 1, 0);
        else check("b_rd_data", b_if.DataOut, exp_b.pop_front());
      end else if (b_if.DataValid !== 1'b0) begin
        check("b_valid_x", b_if.DataValid, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input int ad, input logic [15:0] d);
    a_if.WriteEnable = 1'b1;
    a_if.Address     = 4'(ad);
    a_if.DataIn      = d;
    model_a[ad]      = d;
    tick();
    a_if.WriteEnable = 1'b0;
  endtask

  task automatic rd_a(input int ad);
    a_if.ReadEnable = 1'b1;
    a_if.Address    = 4'(ad);
    exp_a.push_back({16'h0, model_a[ad]});
    tick();
    a_if.ReadEnable = 1'b0;
  endtask

  task automatic wr_b(input int ad, input logic [31:0] d);
    b_if.WriteEnable = 1'b1;
    b_if.Address     = 6'(ad);
    b_if.DataIn      = d;
    model_b[ad]      = d;
    tick();
    b_if.WriteEnable = 1'b0;
  endtask

  task automatic rd_b(input int ad);
    b_if.ReadEnable = 1'b1;
    b_if.Address    = 6'(ad);
    exp_b.push_back(model_b[ad]);
    tick();
    b_if.ReadEnable = 1'b0;
  endtask

  // Starts a clear and counts cycles with Ready low; a write to addr 0 is
  // attempted on the 8th clear cycle and must be ignored.
  task automatic clear_a(output int n);
    a_if.ClearEnable = 1'b1;
    tick();
    a_if.ClearEnable = 1'b0;
    n = 0;
    while (a_if.Ready !== 1'b1 && n < 200) begin
      n++;
      if (n == 8) begin
        a_if.WriteEnable = 1'b1;
        a_if.Address     = 4'd0;
        a_if.DataIn      = 16'hBEEF;
      end
      tick();
      a_if.WriteEnable = 1'b0;
    end
  endtask

  task automatic clear_b(output int n);
    b_if.ClearEnable = 1'b1;
    tick();
    b_if.ClearEnable = 1'b0;
    n = 0;
    while (b_if.Ready !== 1'b1 && n < 200) begin
      n++;
      if (n == 8) begin
        b_if.WriteEnable = 1'b1;
        b_if.Address     = 6'd0;
        b_if.DataIn      = 32'hBEEF;
      end
      tick();
      b_if.WriteEnable = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          n;
    logic [15:0] hold;
    a_if.ReadEnable = 0; a_if.WriteEnable = 0; a_if.ClearEnable = 0;
    a_if.Address = '0; a_if.DataIn = '0;
    b_if.ReadEnable = 0; b_if.WriteEnable = 0; b_if.ClearEnable = 0;
    b_if.Address = '0; b_if.DataIn = '0;

    #12;
    check("a_rst_dataout", a_if.DataOut, 0);
    check("a_rst_valid", a_if.DataValid, 0);
    check("a_rst_ready", a_if.Ready, 1);
    check("b_rst_dataout", b_if.DataOut, 0);
    check("b_rst_ready", b_if.Ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Write then read next cycle; first write lands on the first edge after reset.
    wr_a(3, 16'hA5A5);
    rd_a(3);
    check("a_valid_pulse", a_if.DataValid, 1);
    tick();
    check("a_valid_one_cycle", a_if.DataValid, 0);
    check("a_dataout_hold", a_if.DataOut, 16'hA5A5);

    // Read and write together: read wins, memory untouched.
    wr_a(5, 16'h1234);
    a_if.ReadEnable  = 1'b1;
    a_if.WriteEnable = 1'b1;
    a_if.Address     = 4'd5;
    a_if.DataIn      = 16'hFFFF;
    exp_a.push_back(32'h1234);
    tick();
    a_if.ReadEnable  = 1'b0;
    a_if.WriteEnable = 1'b0;
    rd_a(5);

    // Fill everything, then back-to-back reads.
    for (int i = 0; i < 16; i++) wr_a(i, 16'($urandom));
    for (int i = 15; i >= 0; i--) begin
      rd_a(i);
      check("a_b2b_valid", a_if.DataValid, 1);
    end
    tick();

    // Full clear: 16 cycles with Ready low, DataOut held, everything zero after.
    hold = model_a[0];
    clear_a(n);
    check("a_clear_cycles", n, 16);
    check("a_clear_hold", a_if.DataOut, hold);
    for (int i = 0; i < 16; i++) model_a[i] = '0;
    for (int i = 0; i < 16; i++) rd_a(i);
    tick();

    // Reset after 5 clear cycles: words 0-4 zero, the rest keep their data.
    for (int i = 0; i < 16; i++) wr_a(i, 16'h1000 + 16'(i));
    rd_a(7);
    tick();
    a_if.ClearEnable = 1'b1;
    tick();
    a_if.ClearEnable = 1'b0;
    repeat (5) tick();
    check("a_midclear_ready", a_if.Ready, 0);
    rst_n = 1'b0;
    #1;
    check("a_abort_dataout", a_if.DataOut, 0);
    check("a_abort_valid", a_if.DataValid, 0);
    check("a_abort_ready", a_if.Ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) model_a[i] = '0;
    for (int i = 0; i < 16; i++) rd_a(i);
    tick();

    // Wide instance: top address, 64-cycle clear.
    wr_b(63, 32'hDEADBEEF);
    rd_b(63);
    wr_b(0, 32'h0000_0001);
    rd_b(0);
    tick();
    clear_b(n);
    check("b_clear_cycles", n, 64);
    for (int i = 0; i < 64; i++) model_b[i] = '0;
    rd_b(63);
    rd_b(0);
    rd_b(31);

    repeat (3) tick();
    check("a_drained", exp_a.size(), 0);
    check("b_drained", exp_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
